ucie_pattern_gen_tx: RTL and testbench
======================================

Name: ucie_pattern_gen_tx

Overview:
Parametrised, lane-scalable transmit pattern generator for the UCIe mainband training datapath.
- Produces per-lane 23-bit LFSR PRBS bursts, per-lane ID bursts, or scrambled pass-through data.
- Runs bursts with runtime-programmable lengths under a start/busy/done/abort handshake.
- Sits between the link-training state machine and the lane serialisers.
- Supersedes the fixed 16-lane, fixed-length generator.

Parameters:
NUM_LANES, 16, number of mainband lanes (1..64); lane i uses seed slot i mod 8.
CNT_W, 16, width of burst length inputs and the burst counter.
ID_W, 8, width of the lane-number field in the lane ID word (fixed frame 4+ID_W+4 bits).

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
i_start  in  1  one-cycle request; accepted only in IDLE.
i_mode  in  2  0=LFSR, 1=LANE_ID, 2=SCRAMBLE, 3=RESEED; sampled with accepted i_start.
i_len  in  CNT_W  burst length in UI; sampled with accepted i_start.
i_abort  in  1  terminate current operation.
i_lane_data  in  NUM_LANES  serial data to scramble; bit i = lane i.
o_lane_data  out  NUM_LANES  serial output; bit i = lane i.
o_valid  out  1  o_lane_data carries a burst bit.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low on a clk rising edge resets the block.
- Reset values: all outputs 0; FSM = IDLE; counters 0; all LFSRs loaded with seeds.
- Seed slots 0..7: 23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB, 23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807.
- LFSR (one per seed slot):
  - Feedback fb = s[22]^s[20]^s[15]^s[7]^s[4]^s[1].
  - Next state = {s[21:0], fb}.
  - Lane output bit = s[22], taken before the shift.
  - Advances only in RUN with mode LFSR or SCRAMBLE.
- Lane ID word W (16 bits for ID_W=8):
  - W[3:0] = 4'b1010; W[11:4] = bit-reverse of lane index[7:0]; W[15:12] = 4'b1010.
  - Bit W[k] is sent at burst UI n, with k = n mod 16.
- FSM states: IDLE, LOAD, RUN, FIN.
  - IDLE: on i_start, latch i_mode and i_len, go to LOAD. Otherwise hold, with o_lane_data = 0 and o_valid = 0.
  - LOAD (1 cycle): reload all LFSRs with seeds; clear counters.
    - Mode RESEED, or i_len == 0: go to FIN (no valid UIs).
    - Otherwise: go to RUN.
  - RUN: each cycle registers one UI onto o_lane_data with o_valid = 1, then increments the counter.
    - LFSR mode: lane bit = LFSR bit.
    - LANE_ID mode: lane bit = W[k].
    - SCRAMBLE mode: lane bit = i_lane_data[i] ^ LFSR bit, sampled the same cycle.
    - Once i_len UIs have been registered, go to FIN.
  - FIN (1 cycle): o_done = 1, o_valid = 0, o_lane_data = 0; go to IDLE.
- Timing:
  - i_start at cycle t: first valid UI is visible at cycle t+3 (IDLE → LOAD → RUN, output registered).
  - o_valid is high for exactly i_len cycles.
  - o_done is visible the cycle after the last valid UI.
- Counters:
  - The burst counter never wraps within a burst.
  - i_len = 2^CNT_W-1 is supported.
- i_start while busy: ignored, no queuing.
- i_start in the same cycle that FIN returns to IDLE: ignored. A new start is accepted only when sampled in IDLE.
- i_abort (any non-IDLE state): next cycle FSM = IDLE, o_valid = 0, o_lane_data = 0, no o_done. LFSR state is left as is (the next LOAD reseeds it).
- i_abort takes priority over i_start and over normal completion.
- Reset mid-burst: identical to the reset values above; no o_done.

Optional Feature:
PATTERN_TX_ERR_INJECT_EN.
- Defined:
  - Adds ports i_err_inject (in, 1) and i_err_mask (in, NUM_LANES).
  - In a RUN cycle with i_err_inject = 1, the registered bit of each lane with i_err_mask[i] = 1 is inverted.
  - LFSR state, counters and other lanes are unaffected.
- Undefined: the ports are absent and outputs are never inverted.

Test Plan:
- LFSR: NUM_LANES=16, i_mode=0, i_len=4096 → lane0 first three UIs 0,0,1; lane8 == lane0 on every UI; o_valid high 4096 cycles; o_done at cycle t+3+4096.
- LANE_ID: i_mode=1, i_len=32 → lane1 sends 0,1,0,1,0,0,0,0,0,0,0,1,0,1,0,1 twice; lane0 middle field all 0; o_done once.
- SCRAMBLE: i_mode=2, i_len=8, i_lane_data all ones → each lane equals the inverse of the LFSR-mode stream for the same UI; then a second start reproduces identical output (reseeded).
- Abort: i_mode=0, i_len=100, i_abort at RUN UI 10 → o_valid low next cycle, no o_done, o_busy=0; a following start proceeds normally.
- Boundaries: i_len=0 → o_done at t+2 with no valid UI; RESEED → o_done at t+2; i_start during RUN ignored; rst_n low mid-burst → all outputs 0 next cycle.
- With PATTERN_TX_ERR_INJECT_EN: i_err_mask=16'h0001 and i_err_inject at UI 5 → only lane0 UI 5 is inverted; UI 6 matches the reference stream.

Source files
------------

// File: rtl/ucie_pattern_gen_tx.sv
// ucie_pattern_gen_tx: lane-scalable mainband transmit pattern generator.
// Sends per-lane 23-bit PRBS bursts, per-lane ID bursts or PRBS-scrambled
// pass-through data. Each burst is started by a one-cycle start pulse and can be
// cut short with an abort.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   i_start        one-cycle burst request, accepted only in IDLE
//   i_mode         0=LFSR, 1=LANE_ID, 2=SCRAMBLE, 3=RESEED (latched with i_start)
//   i_len          burst length in UI (latched with i_start)
//   i_abort        terminates the current operation with no done pulse
//   i_lane_data    serial data to scramble, bit i = lane i
//   o_lane_data    registered serial output, bit i = lane i
//   o_valid        o_lane_data carries a burst bit
//   o_busy         high in every state except IDLE
//   o_done         one-cycle completion pulse
//
// Optional build macro PATTERN_TX_ERR_INJECT_EN adds i_err_inject and i_err_mask.
// In a RUN cycle with i_err_inject high, the bit of each masked lane is inverted.
module ucie_pattern_gen_tx #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ID_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [1:0]           i_mode,
    input  logic [CNT_W-1:0]     i_len,
    input  logic                 i_abort,
    input  logic [NUM_LANES-1:0] i_lane_data,
`ifdef PATTERN_TX_ERR_INJECT_EN
    input  logic                 i_err_inject,
    input  logic [NUM_LANES-1:0] i_err_mask,
`endif
    output logic [NUM_LANES-1:0] o_lane_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned FW = ID_W + 8;     // lane ID frame length in UI
    localparam int unsigned KW = $clog2(FW);

    localparam logic [1:0] ModeLfsr     = 2'd0;
    localparam logic [1:0] ModeLaneId   = 2'd1;
    localparam logic [1:0] ModeScramble = 2'd2;
    localparam logic [1:0] ModeReseed   = 2'd3;

    localparam logic [22:0] SEEDS [8] = '{
        23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
        23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
    };

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [KW-1:0]          k_q;
    logic [22:0]            lfsr_q [8];
    logic [NUM_LANES-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   emit;
    logic                   advance;

    function automatic logic [22:0] lfsr_next(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
    endfunction

    // Bit k of the ID frame for a lane: 1010 | bit-reversed index | 1010.
    function automatic logic id_bit(input int unsigned lane, input logic [KW-1:0] k);
        logic [FW-1:0] w;
        logic [31:0]   lane_v;
        lane_v = 32'(lane);
        w = '0;
        w[3:0] = 4'b1010;
        w[FW-1 -: 4] = 4'b1010;
        for (int j = 0; j < int'(ID_W); j++) begin
            w[4+j] = lane_v[ID_W-1-j];
        end
        return w[k];
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN spends one extra cycle after the last UI so that
    // o_done lands one cycle after the last valid bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = StLoad;
            StLoad: state_d = (mode_q == ModeReseed || len_q == '0) ? StFin : StRun;
            StRun:  if (cnt_q == len_q) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (i_abort && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    // Outputs and next UI.
    always_comb begin
        emit    = (state_q == StRun) && (cnt_q != len_q) && !i_abort;
        advance = emit && (mode_q == ModeLfsr || mode_q == ModeScramble);
        data_d  = '0;
        valid_d = emit;
        if (emit) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                unique case (mode_q)
                    ModeLaneId:   data_d[i] = id_bit(i, k_q);
                    ModeScramble: data_d[i] = i_lane_data[i] ^ lfsr_q[3'(i)][22];
                    default:      data_d[i] = lfsr_q[3'(i)][22];
                endcase
            end
`ifdef PATTERN_TX_ERR_INJECT_EN
            if (i_err_inject) begin
                data_d = data_d ^ i_err_mask;
            end
`endif
        end
        o_busy = (state_q != StIdle);
        o_done = (state_q == StFin);
    end

    assign o_lane_data = data_q;
    assign o_valid     = valid_q;

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int s = 0; s < 8; s++) lfsr_q[s] <= SEEDS[s];
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            if (state_q == StIdle && i_start) begin
                mode_q <= i_mode;
                len_q  <= i_len;
            end
            if (state_q == StLoad) begin
                cnt_q <= '0;
                k_q   <= '0;
                for (int s = 0; s < 8; s++) lfsr_q[s] <= SEEDS[s];
            end else if (emit) begin
                cnt_q <= cnt_q + CNT_W'(1);
                k_q   <= (k_q == KW'(FW - 1)) ? '0 : k_q + KW'(1);
                if (advance) begin
                    for (int s = 0; s < 8; s++) lfsr_q[s] <= lfsr_next(lfsr_q[s]);
                end
            end
        end
    end

endmodule

// File: tb/tb_ucie_pattern_gen_tx.sv
module tb_ucie_pattern_gen_tx;

    localparam int NL = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [CW-1:0] i_len = '0;
    logic          i_abort = 1'b0;
    logic [NL-1:0] i_lane_data = '0;
`ifdef PATTERN_TX_ERR_INJECT_EN
    logic          i_err_inject = 1'b0;
    logic [NL-1:0] i_err_mask = '0;
`endif
    logic [NL-1:0] o_lane_data;
    logic          o_valid, o_busy, o_done;

    int n_checks = 0;
    int n_fail = 0;

    // Reference PRBS bit streams, one per seed slot.
    logic prbs [8][4200];

    ucie_pattern_gen_tx #(.NUM_LANES(NL), .CNT_W(CW), .ID_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .i_lane_data (i_lane_data),
`ifdef PATTERN_TX_ERR_INJECT_EN
        .i_err_inject(i_err_inject),
        .i_err_mask  (i_err_mask),
`endif
        .o_lane_data (o_lane_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model();
        logic [22:0] seeds [8];
        logic [22:0] s;
        seeds = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                  23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
        for (int slot = 0; slot < 8; slot++) begin
            s = seeds[slot];
            for (int n = 0; n < 4200; n++) begin
                prbs[slot][n] = s[22];
                // taps 22,20,15,7,4,1
                s = {s[21:0], ^(s & 23'h508092)};
            end
        end
    endtask

    function automatic logic [NL-1:0] exp_word(input logic [1:0] mode, input int n,
                                               input logic [NL-1:0] din);
        logic [NL-1:0] r;
        logic [15:0]   w;
        logic [7:0]    li, rev;
        logic          p;
        r = '0;
        for (int lane = 0; lane < NL; lane++) begin
            li = 8'(lane);
            for (int b = 0; b < 8; b++) rev[7-b] = li[b];
            w = 16'hA00A | {4'h0, rev, 4'h0};
            p = prbs[lane % 8][n];
            case (mode)
                2'd0: r[lane] = p;
                2'd1: r[lane] = w[n % 16];
                2'd2: r[lane] = din[lane] ^ p;
                default: r[lane] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Starts one burst and checks every cycle until the block is idle again.
    // With poke set, i_start is toggled randomly while busy and must be ignored.
    task automatic run_burst(input string name, input logic [1:0] mode, input int len,
                             input bit poke, output logic [2:0] first3);
        int            done_c, n;
        bit            short_b, ev, edn, eb;
        logic [NL-1:0] din, ed;
        short_b = (mode == 2'd3) || (len == 0);
        done_c  = short_b ? 2 : 3 + len;
        first3  = '0;
        for (int c = 1; c <= done_c + 1; c++) begin
            if (c == 1) begin
                i_start = 1'b1;
                i_mode  = mode;
                i_len   = CW'(len);
            end else begin
                i_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                i_mode  = 2'($urandom);
                i_len   = CW'($urandom);
            end
            i_lane_data = (mode == 2'd2 && name == "scramble_ones") ? '1 : NL'($urandom);
            din = i_lane_data;
            step();
            ev  = !short_b && c >= 3 && c <= 2 + len;
            n   = c - 3;
            ed  = ev ? exp_word(mode, n, din) : '0;
            edn = (c == done_c);
            eb  = (c <= done_c);
            n_checks += 4;
            if (o_valid !== ev) begin
                n_fail++;
                $display("FAIL %s c=%0d o_valid got=%b exp=%b", name, c, o_valid, ev);
            end
            if (o_done !== edn) begin
                n_fail++;
                $display("FAIL %s c=%0d o_done got=%b exp=%b", name, c, o_done, edn);
            end
            if (o_busy !== eb) begin
                n_fail++;
                $display("FAIL %s c=%0d o_busy got=%b exp=%b", name, c, o_busy, eb);
            end
            if (o_lane_data !== ed) begin
                n_fail++;
                $display("FAIL %s c=%0d o_lane_data got=%h exp=%h", name, c, o_lane_data, ed);
            end
            if (ev && n < 3) first3[n] = o_lane_data[0];
        end
        i_start = 1'b0;
        step();
        n_checks += 2;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after o_busy got=%b exp=0", name, o_busy);
        end
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after o_valid got=%b exp=0", name, o_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_start = 1'b1;
        i_lane_data = '1;
        step();
        step();
        i_start = 1'b0;
        n_checks += 4;
        if (o_lane_data !== '0) begin
            n_fail++;
            $display("FAIL reset o_lane_data got=%h exp=0", o_lane_data);
        end
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset o_valid got=%b exp=0", o_valid);
        end
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset o_busy got=%b exp=0", o_busy);
        end
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset o_done got=%b exp=0", o_done);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release o_busy got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_lfsr();
        logic [2:0] f3;
        run_burst("lfsr4096", 2'd0, 4096, 1'b0, f3);
        n_checks++;
        if (f3 !== 3'b100) begin
            n_fail++;
            $display("FAIL lfsr_first3 lane0 got=%b exp=%b", f3, 3'b100);
        end
    endtask

    task automatic test_lane_id();
        logic [2:0] f3;
        run_burst("lane_id32", 2'd1, 32, 1'b0, f3);
        n_checks++;
        if (f3 !== 3'b010) begin
            n_fail++;
            $display("FAIL lane_id_first3 lane0 got=%b exp=%b", f3, 3'b010);
        end
    endtask

    task automatic test_scramble();
        logic [2:0] f3;
        run_burst("scramble_ones", 2'd2, 8, 1'b0, f3);
        n_checks++;
        if (f3 !== 3'b011) begin
            n_fail++;
            $display("FAIL scramble_first3 lane0 got=%b exp=%b", f3, 3'b011);
        end
        run_burst("scramble_ones", 2'd2, 8, 1'b0, f3);
        run_burst("scramble_rand", 2'd2, 40, 1'b0, f3);
    endtask

    task automatic test_abort();
        logic [2:0] f3;
        i_mode = 2'd0;
        i_len = CW'(100);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 12; c++) step();
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre o_valid got=%b exp=1", o_valid);
        end
        i_abort = 1'b1;
        i_start = 1'b1;
        step();
        i_abort = 1'b0;
        i_start = 1'b0;
        n_checks += 4;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort o_valid got=%b exp=0", o_valid);
        end
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort o_busy got=%b exp=0", o_busy);
        end
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort o_done got=%b exp=0", o_done);
        end
        if (o_lane_data !== '0) begin
            n_fail++;
            $display("FAIL abort o_lane_data got=%h exp=0", o_lane_data);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks += 2;
            if (o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_after c=%0d o_done got=%b exp=0", c, o_done);
            end
            if (o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_after c=%0d o_busy got=%b exp=0", c, o_busy);
            end
        end
        run_burst("after_abort", 2'd0, 30, 1'b0, f3);
    endtask

    task automatic test_boundaries();
        logic [2:0] f3;
        run_burst("len0", 2'd0, 0, 1'b0, f3);
        run_burst("reseed", 2'd3, 20, 1'b0, f3);
        run_burst("start_ignored", 2'd1, 24, 1'b1, f3);
        run_burst("len1", 2'd0, 1, 1'b1, f3);
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] f3;
        i_mode = 2'd2;
        i_len = CW'(50);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 8; c++) step();
        rst_n = 1'b0;
        step();
        n_checks += 4;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid o_valid got=%b exp=0", o_valid);
        end
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid o_busy got=%b exp=0", o_busy);
        end
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid o_done got=%b exp=0", o_done);
        end
        if (o_lane_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid o_lane_data got=%h exp=0", o_lane_data);
        end
        rst_n = 1'b1;
        step();
        run_burst("after_reset", 2'd0, 20, 1'b0, f3);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        for (int r = 0; r < 8; r++) begin
            run_burst("random", 2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'b1, f3);
        end
    endtask

`ifdef PATTERN_TX_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [NL-1:0] ed;
        i_mode = 2'd0;
        i_len = CW'(10);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            i_err_inject = (c == 8);
            i_err_mask = (c == 8) ? NL'(16'h0001) : NL'($urandom);
            step();
            if (c >= 3 && c <= 12) begin
                ed = exp_word(2'd0, c - 3, '0);
                if (c == 8) ed[0] = ~ed[0];
                n_checks++;
                if (o_lane_data !== ed) begin
                    n_fail++;
                    $display("FAIL err_inject ui=%0d o_lane_data got=%h exp=%h",
                             c - 3, o_lane_data, ed);
                end
            end
        end
        i_err_inject = 1'b0;
        i_err_mask = '0;
    endtask
`endif

    initial begin
        build_model();
        test_reset();
        test_lfsr();
        test_lane_id();
        test_scramble();
        test_abort();
        test_boundaries();
        test_reset_mid_burst();
        test_random();
`ifdef PATTERN_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
